// File: rtl/scan_pkg.sv
// Shared types and the hex-to-7-segment decode for the display scan controller.
package scan_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every COUNT_MAX cycles while enabled, held at 0 otherwise.
module tick_gen #(
  parameter int COUNT_MAX = 20000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (COUNT_MAX > 2) ? $clog2(COUNT_MAX) : 1;

  logic [CW-1:0] count;

  assign tick = enable && (count == CW'(COUNT_MAX - 1));

  always_ff @(posedge clk_in) begin
    if (reset || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scan controller with blanking slots.
// Optional leading-zero blanking is built when SCAN_LZB_EN is defined.
module display_scan_ctrl
  import scan_pkg::*;
#(
  parameter int COUNT_MAX   = 20000,
  parameter int N_DIGITS    = 8,
  parameter int BLANK_TICKS = 1
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [4*N_DIGITS-1:0]       digits_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  output logic [N_DIGITS-1:0]         anodes_out,
  output logic [6:0]                  segments_out,
  output logic                        dp_out,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = (BLANK_TICKS > 2) ? $clog2(BLANK_TICKS) : 1;

  scan_state_t           state, state_nx;
  logic [IW-1:0]         idx, idx_nx, idx_inc;
  logic [BW-1:0]         bcnt, bcnt_nx;
  logic [4*N_DIGITS-1:0] snap_dig, snap_dig_nx;
  logic [N_DIGITS-1:0]   snap_dp, snap_dp_nx;
  logic [N_DIGITS-1:0]   lz_mask;
  logic                  frame_start, wrap_start;
  logic                  run, tick, last_digit;
  logic [3:0]            nib;
  logic [N_DIGITS-1:0]   an_nx;
  logic [6:0]            seg_nx;
  logic                  dp_nx;

  assign run        = enable && (state != IDLE);
  assign last_digit = (idx == IW'(N_DIGITS - 1));
  assign idx_inc    = last_digit ? '0 : idx + IW'(1);

  tick_gen #(.COUNT_MAX(COUNT_MAX)) u_tick_gen (
    .clk_in (clk_in),
    .reset  (reset),
    .enable (run),
    .tick   (tick)
  );

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    bcnt_nx     = bcnt;
    frame_start = 1'b0;
    wrap_start  = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
      bcnt_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx    = SHOW;
          idx_nx      = '0;
          bcnt_nx     = '0;
          frame_start = 1'b1;
        end
        SHOW: if (tick) begin
          if (BLANK_TICKS == 0) begin
            idx_nx      = idx_inc;
            frame_start = last_digit;
            wrap_start  = last_digit;
          end else begin
            state_nx = BLANK;
            bcnt_nx  = '0;
          end
        end
        BLANK: if (tick) begin
          if (bcnt == BW'(BLANK_TICKS - 1)) begin
            state_nx    = SHOW;
            idx_nx      = idx_inc;
            bcnt_nx     = '0;
            frame_start = last_digit;
            wrap_start  = last_digit;
          end else begin
            bcnt_nx = bcnt + BW'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign snap_dig_nx = frame_start ? digits_in : snap_dig;
  assign snap_dp_nx  = frame_start ? dp_in     : snap_dp;

`ifdef SCAN_LZB_EN
  // Zeros above the first nonzero (or dp-marked) digit stay dark; digit 0 always shows.
  always_comb begin
    logic in_run;
    lz_mask = '0;
    in_run  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (in_run && (snap_dig_nx[4*i +: 4] == 4'h0) && !snap_dp_nx[i]) begin
        lz_mask[i] = 1'b1;
      end else begin
        in_run = 1'b0;
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Outputs are decoded from the next-state view so the registers line up with the FSM.
  always_comb begin
    nib    = '0;
    an_nx  = '1;
    seg_nx = SEG_BLANK;
    dp_nx  = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_nx == IW'(i)) nib = snap_dig_nx[4*i +: 4];
    end
    if (state_nx == SHOW && !lz_mask[idx_nx]) begin
      an_nx[idx_nx] = 1'b0;
      seg_nx        = seg_decode(nib);
      dp_nx         = ~snap_dp_nx[idx_nx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      bcnt         <= '0;
      snap_dig     <= '0;
      snap_dp      <= '0;
      anodes_out   <= '1;
      segments_out <= SEG_BLANK;
      dp_out       <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      bcnt         <= bcnt_nx;
      snap_dig     <= snap_dig_nx;
      snap_dp      <= snap_dp_nx;
      anodes_out   <= an_nx;
      segments_out <= seg_nx;
      dp_out       <= dp_nx;
      frame_done   <= wrap_start;
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a blanking build (A) and a contiguous build (B) run side by side
// against a cycle-index reference model of the scan schedule.
module tb_display_scan_ctrl;

  localparam int CM = 4;
  localparam int ND = 4;
  localparam int PER_A = ND * 2 * CM;
  localparam int PER_B = ND * 1 * CM;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [1:0] idx_a, idx_b;

  int vectors = 0;
  int miscompares = 0;

  bit          run_m = 0;
  int          t_m = 0;
  logic [15:0] snap_a = '0, snap_b = '0;
  logic [3:0]  sdp_a = '0, sdp_b = '0;
  logic [14:0] exp_a, exp_b;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_ctrl #(.COUNT_MAX(CM), .N_DIGITS(ND), .BLANK_TICKS(1)) dut_a (
    .clk_in(clk_in), .reset(reset), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .anodes_out(an_a), .segments_out(seg_a), .dp_out(dp_a), .digit_idx(idx_a), .frame_done(fd_a));

  display_scan_ctrl #(.COUNT_MAX(CM), .N_DIGITS(ND), .BLANK_TICKS(0)) dut_b (
    .clk_in(clk_in), .reset(reset), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .anodes_out(an_b), .segments_out(seg_b), .dp_out(dp_b), .digit_idx(idx_b), .frame_done(fd_b));

  always #5 clk_in = ~clk_in;

  // A digit is a leading zero when it and every digit above it are zero with no dp set.
  function automatic bit lz_blank(logic [15:0] snap, logic [3:0] sdp, int dig);
    bit blank = (dig != 0);
    for (int i = ND - 1; i >= dig; i--) if (snap[i*4 +: 4] != 4'h0 || sdp[i]) blank = 0;
`ifndef SCAN_LZB_EN
    blank = 0;
`endif
    return blank;
  endfunction

  function automatic logic [14:0] expect_out(int bt, logic [15:0] snap, logic [3:0] sdp);
    int per, slot, dig;
    logic [3:0] an;
    logic [6:0] seg;
    logic dpo, fd;
    if (!run_m) return {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0};
    per  = ND * (1 + bt) * CM;
    slot = t_m / CM;
    dig  = (slot / (1 + bt)) % ND;
    an   = 4'hF;
    seg  = 7'h7F;
    dpo  = 1'b1;
    fd   = (t_m % per == 0) && (t_m > 0);
    if (slot % (1 + bt) == 0 && !lz_blank(snap, sdp, dig)) begin
      an[dig] = 1'b0;
      seg     = seg_tab[snap[dig*4 +: 4]];
      dpo     = ~sdp[dig];
    end
    return {an, seg, dpo, dig[1:0], fd};
  endfunction

  // Advance the reference by one clock using the inputs presented before the edge.
  task automatic step();
    if (reset) begin
      run_m = 0; t_m = 0; snap_a = '0; sdp_a = '0; snap_b = '0; sdp_b = '0;
    end else if (!enable) begin
      run_m = 0; t_m = 0;
    end else begin
      if (!run_m) begin run_m = 1; t_m = 0; end
      else t_m++;
      if (t_m % PER_A == 0) begin snap_a = digits_in; sdp_a = dp_in; end
      if (t_m % PER_B == 0) begin snap_b = digits_in; sdp_b = dp_in; end
    end
    @(posedge clk_in);
    #1;
    exp_a = expect_out(1, snap_a, sdp_a);
    exp_b = expect_out(0, snap_b, sdp_b);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; digits_in = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if ({an_a, seg_a, dp_a, idx_a, fd_a} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_a: got %h, expected %h", {an_a, seg_a, dp_a, idx_a, fd_a}, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
      end
      vectors++;
      if ({an_b, seg_b, dp_b, idx_b, fd_b} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_b: got %h, expected %h", {an_b, seg_b, dp_b, idx_b, fd_b}, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
      end
    end
  endtask

  task automatic test_scan();
    reset = 1'b0; enable = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000;
    for (int c = 0; c < 70; c++) begin
      step();
      if (c == 0) begin
        vectors++;
        if ({an_a, seg_a} !== {4'b1110, 7'h19}) begin
          miscompares++;
          $display("FAIL scan_first_digit: got %h, expected %h", {an_a, seg_a}, {4'b1110, 7'h19});
        end
      end
      vectors++;
      if ({an_a, seg_a, dp_a, idx_a, fd_a} !== exp_a) begin
        miscompares++;
        $display("FAIL scan_a t=%0d: got %h, expected %h", t_m, {an_a, seg_a, dp_a, idx_a, fd_a}, exp_a);
      end
      vectors++;
      if ({an_b, seg_b, dp_b, idx_b, fd_b} !== exp_b) begin
        miscompares++;
        $display("FAIL scan_b t=%0d: got %h, expected %h", t_m, {an_b, seg_b, dp_b, idx_b, fd_b}, exp_b);
      end
    end
  endtask

  task automatic test_midframe();
    int guard = 0;
    while (!(run_m && t_m % PER_A == 9) && guard < 100) begin step(); guard++; end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL midframe_align: waited %0d cycles, limit 100", guard);
    end
    digits_in = 16'hABCD;
    for (int c = 0; c < 70; c++) begin
      step();
      vectors++;
      if ({an_a, seg_a, dp_a, idx_a, fd_a} !== exp_a) begin
        miscompares++;
        $display("FAIL midframe_a t=%0d: got %h, expected %h", t_m, {an_a, seg_a, dp_a, idx_a, fd_a}, exp_a);
      end
      vectors++;
      if ({an_b, seg_b, dp_b, idx_b, fd_b} !== exp_b) begin
        miscompares++;
        $display("FAIL midframe_b t=%0d: got %h, expected %h", t_m, {an_b, seg_b, dp_b, idx_b, fd_b}, exp_b);
      end
    end
  endtask

  task automatic test_dp();
    digits_in = 16'h8888; dp_in = 4'b0100;
    for (int c = 0; c < 72; c++) begin
      step();
      vectors++;
      if ({an_a, seg_a, dp_a, idx_a, fd_a} !== exp_a) begin
        miscompares++;
        $display("FAIL dp_a t=%0d: got %h, expected %h", t_m, {an_a, seg_a, dp_a, idx_a, fd_a}, exp_a);
      end
      vectors++;
      if ({an_b, seg_b, dp_b, idx_b, fd_b} !== exp_b) begin
        miscompares++;
        $display("FAIL dp_b t=%0d: got %h, expected %h", t_m, {an_b, seg_b, dp_b, idx_b, fd_b}, exp_b);
      end
    end
  endtask

  task automatic test_enable_drop();
    int guard = 0;
    digits_in = 16'h0050; dp_in = 4'b0000;
    while (!(run_m && (t_m / CM) % 2 == 0 && ((t_m / CM) / 2) % ND == 2) && guard < 100) begin
      step(); guard++;
    end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL enable_drop_align: waited %0d cycles, limit 100", guard);
    end
    enable = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) enable = 1'b1;
      step();
      vectors++;
      if ({an_a, seg_a, dp_a, idx_a, fd_a} !== exp_a) begin
        miscompares++;
        $display("FAIL enable_drop_a step=%0d: got %h, expected %h", c, {an_a, seg_a, dp_a, idx_a, fd_a}, exp_a);
      end
      vectors++;
      if ({an_b, seg_b, dp_b, idx_b, fd_b} !== exp_b) begin
        miscompares++;
        $display("FAIL enable_drop_b step=%0d: got %h, expected %h", c, {an_b, seg_b, dp_b, idx_b, fd_b}, exp_b);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 14) == 0) digits_in = 16'($urandom());
      if ($urandom_range(0, 3) == 0) digits_in = digits_in & 16'h00FF;
      if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom());
      step();
      vectors++;
      if ({an_a, seg_a, dp_a, idx_a, fd_a} !== exp_a) begin
        miscompares++;
        $display("FAIL random_a cycle=%0d: got %h, expected %h", c, {an_a, seg_a, dp_a, idx_a, fd_a}, exp_a);
      end
      vectors++;
      if ({an_b, seg_b, dp_b, idx_b, fd_b} !== exp_b) begin
        miscompares++;
        $display("FAIL random_b cycle=%0d: got %h, expected %h", c, {an_b, seg_b, dp_b, idx_b, fd_b}, exp_b);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_dp();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
